// File: rtl/mio_pkg.sv
// Shared definitions for the MIO bus initiator: FSM state encoding,
// address-decoder region nibbles and the default word stride.
package mio_pkg;

   typedef enum logic [2:0] {
      IDLE,
      REQ,
      RD,
      CAP,
      WR,
      FIN
   } mio_state_e;

   localparam logic [3:0] REGION_RAM   = 4'h0;
   localparam logic [3:0] REGION_RAND  = 4'hC;
   localparam logic [3:0] REGION_KBD   = 4'hD;
   localparam logic [3:0] REGION_GPIOE = 4'hE;
   localparam logic [3:0] REGION_GPIOF = 4'hF;

   localparam int unsigned MIO_ADDR_STEP = 4;

endpackage

// File: rtl/mio_dma_master.sv
// Block-copy bus initiator for the MIO address/data bus (RD/CAP/WR per word).
// Optional constant-fill mode is enabled by defining MIO_DMA_FILL_EN.
module mio_dma_master
   import mio_pkg::*;
#(
   parameter int unsigned CNT_W     = 16,
   parameter int unsigned ADDR_STEP = MIO_ADDR_STEP
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             abort,
   input  logic [31:0]      src_addr,
   input  logic [31:0]      dst_addr,
   input  logic [CNT_W-1:0] word_cnt,
`ifdef MIO_DMA_FILL_EN
   input  logic             fill_mode,
   input  logic [31:0]      fill_data,
`endif
   output logic             bus_req,
   input  logic             bus_gnt,
   output logic [31:0]      addr_bus,
   output logic             mem_w,
   output logic [31:0]      cpu_data2bus,
   input  logic [31:0]      cpu_data4bus,
   output logic             busy,
   output logic             done,
   output logic             aborted,
   output logic [CNT_W-1:0] words_done
);

   mio_state_e       state, state_nx;
   logic [31:0]      src_q, dst_q, data_buf;
   logic [CNT_W-1:0] remaining, words_done_q;
   logic             aborted_q;
   logic             fill_on;
   logic [31:0]      wr_data;
   logic             last_word;

   assign last_word = (remaining == CNT_W'(1));

`ifdef MIO_DMA_FILL_EN
   logic        fill_q;
   logic [31:0] fill_data_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fill_q      <= 1'b0;
         fill_data_q <= '0;
      end else if (state == IDLE && start && word_cnt != '0) begin
         fill_q      <= fill_mode;
         fill_data_q <= fill_data;
      end
   end

   assign fill_on = fill_q;
   assign wr_data = fill_q ? fill_data_q : data_buf;
`else
   assign fill_on = 1'b0;
   assign wr_data = data_buf;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE: if (start) state_nx = (word_cnt != '0) ? REQ : FIN;
         REQ: begin
            if (abort)        state_nx = FIN;
            else if (bus_gnt) state_nx = fill_on ? WR : RD;
         end
         RD:  state_nx = CAP;
         CAP: state_nx = WR;
         WR: begin
            if (last_word || abort) state_nx = FIN;
            else                    state_nx = fill_on ? WR : RD;
         end
         FIN: state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Bus outputs decode straight from state so an async reset drops them at once.
   always_comb begin
      bus_req      = 1'b0;
      busy         = 1'b0;
      done         = 1'b0;
      addr_bus     = '0;
      mem_w        = 1'b0;
      cpu_data2bus = '0;
      unique case (state)
         REQ: begin
            bus_req = 1'b1;
            busy    = 1'b1;
         end
         RD, CAP: begin
            bus_req  = 1'b1;
            busy     = 1'b1;
            addr_bus = src_q;
         end
         WR: begin
            bus_req      = 1'b1;
            busy         = 1'b1;
            addr_bus     = dst_q;
            mem_w        = 1'b1;
            cpu_data2bus = wr_data;
         end
         FIN:     done = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         src_q        <= '0;
         dst_q        <= '0;
         data_buf     <= '0;
         remaining    <= '0;
         words_done_q <= '0;
         aborted_q    <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (start) begin
                  words_done_q <= '0;
                  aborted_q    <= 1'b0;
                  if (word_cnt != '0) begin
                     src_q     <= src_addr;
                     dst_q     <= dst_addr;
                     remaining <= word_cnt;
                  end
               end
            end
            REQ: if (abort) aborted_q <= 1'b1;
            CAP: data_buf <= cpu_data4bus;
            WR: begin
               src_q        <= src_q + 32'(ADDR_STEP);
               dst_q        <= dst_q + 32'(ADDR_STEP);
               remaining    <= remaining - CNT_W'(1);
               words_done_q <= words_done_q + CNT_W'(1);
               if (abort) aborted_q <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign aborted    = aborted_q;
   assign words_done = words_done_q;

endmodule

// File: tb/tb_mio_dma_master.sv
// Scoreboard bench for mio_dma_master: a registered-read memory model answers the
// bus, expected writes are queued at command issue and popped as mem_w cycles occur.
module tb_mio_dma_master;

   localparam int CNT_W = 16;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             start = 1'b0;
   logic             abort = 1'b0;
   logic [31:0]      src_addr = '0;
   logic [31:0]      dst_addr = '0;
   logic [CNT_W-1:0] word_cnt = '0;
   logic             fill_mode = 1'b0;
   logic [31:0]      fill_data = '0;
   logic             bus_req;
   logic             bus_gnt = 1'b1;
   logic [31:0]      addr_bus;
   logic             mem_w;
   logic [31:0]      cpu_data2bus;
   logic [31:0]      cpu_data4bus;
   logic             busy;
   logic             done;
   logic             aborted;
   logic [CNT_W-1:0] words_done;

   mio_dma_master #(.CNT_W(CNT_W), .ADDR_STEP(4)) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .abort        (abort),
      .src_addr     (src_addr),
      .dst_addr     (dst_addr),
      .word_cnt     (word_cnt),
`ifdef MIO_DMA_FILL_EN
      .fill_mode    (fill_mode),
      .fill_data    (fill_data),
`endif
      .bus_req      (bus_req),
      .bus_gnt      (bus_gnt),
      .addr_bus     (addr_bus),
      .mem_w        (mem_w),
      .cpu_data2bus (cpu_data2bus),
      .cpu_data4bus (cpu_data4bus),
      .busy         (busy),
      .done         (done),
      .aborted      (aborted),
      .words_done   (words_done)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] a;
      logic [31:0] d;
   } wr_t;

   wr_t         sb[$];
   logic [31:0] mem [256];
   int          checks = 0;
   int          errors = 0;
   int          done_cnt = 0;
   bit          req_seen = 1'b0;

   function automatic logic [31:0] init_word(input int idx);
      case (idx)
         0:       return 32'd11;
         1:       return 32'd22;
         2:       return 32'd33;
         3:       return 32'd44;
         default: return 32'h1000_0000 + 32'(idx);
      endcase
   endfunction

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", tag, obs, exp);
      end
   endtask

   // Memory responder: contents reload while reset is held, reads registered.
   always @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
      end else if (mem_w) begin
         mem[addr_bus[9:2]] <= cpu_data2bus;
      end
      cpu_data4bus <= mem[addr_bus[9:2]];
   end

   always @(negedge clk) begin
      wr_t e;
      if (done) done_cnt++;
      if (bus_req) req_seen = 1'b1;
      if (mem_w) begin
         if (sb.size() == 0) begin
            check_val("unexpected_wr", {31'b0, mem_w}, 32'd0);
         end else begin
            e = sb.pop_front();
            check_val("wr_addr", addr_bus, e.a);
            check_val("wr_data", cpu_data2bus, e.d);
         end
      end
   end

   task automatic push_copy(input logic [31:0] src, input logic [31:0] dst, input int n);
      logic [31:0] s;
      for (int i = 0; i < n; i++) begin
         s = src + 32'(4 * i);
         sb.push_back({dst + 32'(4 * i), init_word(int'(s[9:2]))});
      end
   endtask

   task automatic start_cmd(input logic [31:0] src, input logic [31:0] dst, input logic [CNT_W-1:0] cnt);
      @(negedge clk);
      src_addr = src;
      dst_addr = dst;
      word_cnt = cnt;
      start    = 1'b1;
      @(negedge clk);
      start    = 1'b0;
   endtask

   task automatic wait_done(input int limit, output int cyc);
      cyc = 0;
      while (!done && cyc < limit) begin
         @(negedge clk);
         cyc++;
      end
      if (!done) check_val("done_timeout", {31'b0, done}, 32'd1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
      $fatal(1, "watchdog");
   end

   initial begin
      int cyc;
      int bad;

      // Reset state
      @(negedge clk);
      check_val("rst_bus_req", {31'b0, bus_req}, 32'd0);
      check_val("rst_addr", addr_bus, 32'd0);
      check_val("rst_mem_w", {31'b0, mem_w}, 32'd0);
      check_val("rst_wdata", cpu_data2bus, 32'd0);
      check_val("rst_busy", {31'b0, busy}, 32'd0);
      check_val("rst_done", {31'b0, done}, 32'd0);
      check_val("rst_aborted", {31'b0, aborted}, 32'd0);
      check_val("rst_words", 32'(words_done), 32'd0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);

      // Four-word copy with grant already high
      done_cnt = 0;
      push_copy(32'h0, 32'h100, 4);
      start_cmd(32'h0, 32'h100, 16'd4);
      check_val("copy_busy", {31'b0, busy}, 32'd1);
      wait_done(60, cyc);
      check_val("copy_done_lat", 32'(cyc), 32'd13);
      check_val("copy_words", 32'(words_done), 32'd4);
      check_val("copy_aborted", {31'b0, aborted}, 32'd0);
      check_val("copy_busy_fin", {31'b0, busy}, 32'd0);
      repeat (2) @(negedge clk);
      check_val("copy_done_once", 32'(done_cnt), 32'd1);
      check_val("copy_sb_left", 32'(sb.size()), 32'd0);

      // Zero-length command
      done_cnt = 0;
      req_seen = 1'b0;
      start_cmd(32'h40, 32'h500, 16'd0);
      check_val("zero_done", {31'b0, done}, 32'd1);
      check_val("zero_busy", {31'b0, busy}, 32'd0);
      check_val("zero_words", 32'(words_done), 32'd0);
      repeat (3) @(negedge clk);
      check_val("zero_done_once", 32'(done_cnt), 32'd1);
      check_val("zero_no_req", {31'b0, req_seen}, 32'd0);

      // Delayed grant, plus a start that must be ignored while busy
      bus_gnt = 1'b0;
      done_cnt = 0;
      push_copy(32'h20, 32'h140, 1);
      start_cmd(32'h20, 32'h140, 16'd1);
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         if (bus_req !== 1'b1 || addr_bus !== 32'd0 || mem_w !== 1'b0) bad++;
         start = (i == 3);
         if (i == 3) begin
            src_addr = 32'h80;
            dst_addr = 32'h180;
            word_cnt = 16'd5;
         end
         @(negedge clk);
      end
      check_val("gnt_wait_bus", 32'(bad), 32'd0);
      bus_gnt = 1'b1;
      @(negedge clk);
      check_val("gnt_first_rd", addr_bus, 32'h20);
      check_val("gnt_rd_mem_w", {31'b0, mem_w}, 32'd0);
      wait_done(20, cyc);
      check_val("gnt_words", 32'(words_done), 32'd1);
      repeat (2) @(negedge clk);
      check_val("gnt_done_once", 32'(done_cnt), 32'd1);
      check_val("gnt_sb_left", 32'(sb.size()), 32'd0);

      // Abort raised during the third word's CAP cycle
      done_cnt = 0;
      push_copy(32'h0, 32'h300, 3);
      start_cmd(32'h0, 32'h300, 16'd8);
      repeat (8) @(negedge clk);
      abort = 1'b1;
      wait_done(20, cyc);
      check_val("abort_lat", 32'(cyc), 32'd2);
      abort = 1'b0;
      check_val("abort_flag", {31'b0, aborted}, 32'd1);
      check_val("abort_words", 32'(words_done), 32'd3);
      repeat (2) @(negedge clk);
      check_val("abort_held", {31'b0, aborted}, 32'd1);
      check_val("abort_done_once", 32'(done_cnt), 32'd1);
      check_val("abort_sb_left", 32'(sb.size()), 32'd0);

      // Source address wrap past 0xFFFFFFFC
      push_copy(32'hFFFF_FFFC, 32'h200, 2);
      start_cmd(32'hFFFF_FFFC, 32'h200, 16'd2);
      check_val("wrap_abort_clr", {31'b0, aborted}, 32'd0);
      repeat (4) @(negedge clk);
      check_val("wrap_rd2_addr", addr_bus, 32'h0);
      check_val("wrap_rd2_req", {31'b0, bus_req}, 32'd1);
      wait_done(20, cyc);
      check_val("wrap_words", 32'(words_done), 32'd2);
      repeat (2) @(negedge clk);
      check_val("wrap_sb_left", 32'(sb.size()), 32'd0);

      // Asynchronous reset in the middle of a WR cycle
      push_copy(32'h10, 32'h240, 1);
      start_cmd(32'h10, 32'h240, 16'd4);
      repeat (3) @(negedge clk);
      check_val("mid_wr_mem_w", {31'b0, mem_w}, 32'd1);
      done_cnt = 0;
      #1 rst = 1'b0;
      #1;
      check_val("arst_mem_w", {31'b0, mem_w}, 32'd0);
      check_val("arst_bus_req", {31'b0, bus_req}, 32'd0);
      check_val("arst_addr", addr_bus, 32'd0);
      check_val("arst_busy", {31'b0, busy}, 32'd0);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check_val("arst_no_done", 32'(done_cnt), 32'd0);
      check_val("arst_words", 32'(words_done), 32'd0);
      check_val("arst_sb_left", 32'(sb.size()), 32'd0);

`ifdef MIO_DMA_FILL_EN
      // Constant fill into GPIO space: back-to-back write cycles
      fill_mode = 1'b1;
      fill_data = 32'hDEAD_BEEF;
      for (int i = 0; i < 3; i++) sb.push_back({32'hE000_0000 + 32'(4 * i), 32'hDEAD_BEEF});
      start_cmd(32'h0, 32'hE000_0000, 16'd3);
      fill_mode = 1'b0;
      wait_done(20, cyc);
      check_val("fill_lat", 32'(cyc), 32'd4);
      check_val("fill_words", 32'(words_done), 32'd3);
      repeat (2) @(negedge clk);
      check_val("fill_sb_left", 32'(sb.size()), 32'd0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mio_dma_master.md
Name: mio_dma_master

Overview:
- Bus initiator for the MIO address/data bus. Issues reads and writes on the same addr_bus/mem_w/data signals that the MIO address decoder responds to.
- Copies a block of 32-bit words from a source address range to a destination range: data RAM at 0x0xxxxxxx, GPIO at 0xE/0xF, keyboard/rand at 0xC/0xD.
- Sits beside the CPU behind an external bus arbiter (bus_req/bus_gnt). Its bus outputs are zero whenever it does not own the bus, so they can be OR-merged with the CPU's.

Parameters:
- CNT_W, 16, width of word-count and progress counters.
- ADDR_STEP, 4, byte increment per word (word-aligned addressing).

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle command strobe; ignored unless busy=0.
- abort  input  1  level; stop at next word boundary.
- src_addr  input  32  source byte address, sampled at start.
- dst_addr  input  32  destination byte address, sampled at start.
- word_cnt  input  CNT_W  number of words, sampled at start.
- bus_req  output  1  request bus ownership.
- bus_gnt  input  1  arbiter grant; must stay high until bus_req falls.
- addr_bus  output  32  bus address.
- mem_w  output  1  bus write enable.
- cpu_data2bus  output  32  bus write data.
- cpu_data4bus  input  32  bus read data; registered by the responder, valid one cycle after the read address.
- busy  output  1  command in progress.
- done  output  1  one-cycle pulse at completion or abort.
- aborted  output  1  held high after an aborted command until next start.
- words_done  output  CNT_W  words fully written in current/last command.

Behaviour:
Reset (rst=0, async):
- State IDLE.
- All outputs 0, including addr_bus, mem_w, cpu_data2bus, busy, done, aborted, words_done.
- Internal src/dst/remaining/data_buf cleared.

States:
- IDLE
  - start=1 and word_cnt!=0: latch src, dst, remaining=word_cnt; words_done<=0, aborted<=0, busy<=1; go REQ.
  - start=1 and word_cnt==0: done pulses next cycle, busy stays 0, words_done<=0, no bus_req.
- REQ
  - bus_req=1. Stay until bus_gnt=1, then go RD.
  - abort while in REQ: go FIN with aborted=1, no bus cycles.
- RD
  - addr_bus=src, mem_w=0, one cycle. Go CAP.
- CAP
  - addr_bus held at src, mem_w=0.
  - data_buf<=cpu_data4bus at end of cycle. Go WR.
- WR
  - addr_bus=dst, mem_w=1, cpu_data2bus=data_buf, one cycle.
  - Then: src+=ADDR_STEP, dst+=ADDR_STEP (32-bit wrap, no carry out), remaining-=1, words_done+=1.
  - Go FIN if remaining becomes 0 or abort=1 (aborted<=1 on abort); otherwise RD.
- FIN
  - bus_req<=0, busy<=0, done=1 for exactly one cycle. Go IDLE.

Bus and handshake rules:
- bus_req stays high from entry to REQ through the last WR cycle.
- addr_bus, mem_w and cpu_data2bus are 0 in IDLE, REQ and FIN.
- Throughput: 3 cycles per copied word after grant.
- Latency: start to first RD = 2 cycles with bus_gnt already high.
- abort is sampled only in REQ and at the end of WR; a word in flight always completes.
- start while busy=1 is ignored and does not alter the latched parameters.
- Reset mid-transfer: bus drops immediately, no done pulse.

Optional Feature:
- Macro MIO_DMA_FILL_EN.
- Defined:
  - Adds input fill_mode (1) and fill_data (32), both sampled at start.
  - With fill_mode=1: skip RD/CAP and loop WR only, cpu_data2bus=fill_data, 1 cycle per word; src unused.
- Undefined:
  - Ports absent; copy only.

Decomposition:
- Shared package mio_pkg holds:
  - state enum (IDLE, REQ, RD, CAP, WR, FIN);
  - region constants REGION_RAM=4'h0, REGION_RAND=4'hC, REGION_KBD=4'hD, REGION_GPIOE=4'hE, REGION_GPIOF=4'hF;
  - ADDR_STEP default.
- No sub-module. The single FSM plus datapath registers is natural.

Test Plan:
- Copy: RAM words 0x00000000..0x0000000C preloaded 11,22,33,44; src=0x0, dst=0x00000100, cnt=4, gnt tied 1 -> dst reads 11,22,33,44. done pulses once, 12 cycles after first RD. words_done=4.
- word_cnt=0 -> done pulses on next cycle, bus_req never rises, words_done=0.
- Grant delay: bus_gnt held 0 for 10 cycles -> addr_bus/mem_w stay 0 and bus_req stays 1. First RD on the cycle after gnt rises.
- Abort: cnt=8, abort asserted during 3rd word's CAP -> 3rd word written, then done, aborted=1, words_done=3.
- Wrap: src=0xFFFFFFFC, cnt=2 -> second read address 0x00000000. Also assert reset during a WR cycle -> mem_w falls asynchronously, no done.
- With MIO_DMA_FILL_EN: fill_mode=1, fill_data=0xDEADBEEF, dst=0xE0000000, cnt=3 -> three consecutive write cycles at 0xE0000000/4/8, then done.
